// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, result {rem, quo}.
// Divide-by-zero short-circuits to a zero result; annul or reset discards an in-flight divide.
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  // Magnitude of an operand; only negative values in signed mode are negated.
  function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] val, input logic sgn_mode);
    abs_op = (sgn_mode && val[DATA_W-1]) ? (~val + DATA_W'(1)) : val;
  endfunction

  function automatic logic [DATA_W-1:0] fix_sign(input logic [DATA_W-1:0] val, input logic neg);
    fix_sign = neg ? (~val + DATA_W'(1)) : val;
  endfunction

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [DATA_W-1:0]   r_dq, w_dq;
  logic [DATA_W-1:0]   r_dsr, w_dsr;
  logic [DATA_W-1:0]   r_rem, w_rem;
  logic                r_signed, w_signed;
  logic                r_sign1, w_sign1;
  logic                r_sign2, w_sign2;
  logic [2*DATA_W-1:0] r_result, w_result;
  logic                r_ready, w_ready;

  logic [DATA_W:0]     w_partial;
  logic [DATA_W:0]     w_diff;
  logic                w_qbit;
  logic [DATA_W-1:0]   w_rem_it;
  logic [DATA_W-1:0]   w_dq_it;
  logic                w_neg_q;
  logic                w_neg_r;

  // r_dq starts as the dividend and fills with quotient bits from the LSB as it shifts out.
  always_comb begin
    w_partial = {r_rem, r_dq[DATA_W-1]};
    w_diff    = w_partial - {1'b0, r_dsr};
    w_qbit    = ~w_diff[DATA_W];
    w_rem_it  = w_qbit ? w_diff[DATA_W-1:0] : w_partial[DATA_W-1:0];
    w_dq_it   = {r_dq[DATA_W-2:0], w_qbit};
    w_neg_q   = r_signed & (r_sign1 ^ r_sign2);
    w_neg_r   = r_signed & r_sign1;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt      = r_cnt;
    w_dq       = r_dq;
    w_dsr      = r_dsr;
    w_rem      = r_rem;
    w_signed   = r_signed;
    w_sign1    = r_sign1;
    w_sign2    = r_sign2;
    w_result   = r_result;
    w_ready    = r_ready;
    case (r_state)
      S_FREE: begin
        w_result = '0;
        w_ready  = 1'b0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nx = S_BYZERO;
          end else begin
            w_state_nx = S_ON;
            w_dq       = abs_op(opdata1_i, signed_div_i);
            w_dsr      = abs_op(opdata2_i, signed_div_i);
            w_rem      = '0;
            w_cnt      = '0;
            w_signed   = signed_div_i;
            w_sign1    = opdata1_i[DATA_W-1];
            w_sign2    = opdata2_i[DATA_W-1];
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          w_state_nx = S_FREE;
          w_result   = '0;
          w_ready    = 1'b0;
        end else begin
          w_state_nx = S_END;
          w_result   = '0;
          w_ready    = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nx = S_FREE;
          w_result   = '0;
          w_ready    = 1'b0;
        end else begin
          w_rem = w_rem_it;
          w_dq  = w_dq_it;
          w_cnt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            w_state_nx = S_END;
            w_result   = {fix_sign(w_rem_it, w_neg_r), fix_sign(w_dq_it, w_neg_q)};
            w_ready    = 1'b1;
          end
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          w_state_nx = S_FREE;
          w_result   = '0;
          w_ready    = 1'b0;
        end
      end
      default: begin
        w_state_nx = S_FREE;
        w_result   = '0;
        w_ready    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_dq     <= '0;
      r_dsr    <= '0;
      r_rem    <= '0;
      r_signed <= 1'b0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt;
      r_dq     <= w_dq;
      r_dsr    <= w_dsr;
      r_rem    <= w_rem;
      r_signed <= w_signed;
      r_sign1  <= w_sign1;
      r_sign2  <= w_sign2;
      r_result <= w_result;
      r_ready  <= w_ready;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboarded bench for div_iter: the driver queues hand-computed results,
// and the monitor pops and compares one entry on every rising edge of ready_o.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];
  logic ready_prev = 1'b0;

  div_iter #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare the presented result against the oldest expected entry.
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: got result %h with no divide expected", result);
      end else begin
        chk("result", result, sb.pop_front());
      end
    end
    ready_prev <= ready;
  end

  // Issue a divide with start held, check latency, optionally hold in END, then drop start.
  task automatic issue(input string name, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input int hold, input logic scramble);
    int n;
    sb.push_back(exp);
    signed_div = sg; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    if (scramble) begin
      op1 = 32'h1234_5678; op2 = 32'h0000_0000; signed_div = ~sg;
    end
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_result"}, result, exp);
      chk({name, "_hold_ready"}, 64'(ready), 64'd1);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk({name, "_drop_ready"}, 64'(ready), 64'd0);
    chk({name, "_drop_result"}, result, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic no_ready(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ready) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    rst = 1'b1; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1
    issue("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32, 0, 1'b0);
    // T2
    issue("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 32, 0, 1'b0);
    issue("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 32, 0, 1'b0);
    issue("s-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E, 32, 0, 1'b0);
    // T3
    issue("u5_0", 1'b0, 32'd5, 32'd0, 64'h0, 1, 0, 1'b0);
    issue("s-5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 64'h0, 1, 0, 1'b0);
    issue("uFFFF_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 32, 0, 1'b0);
    issue("uFFFF_FFFF", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h00000000_00000001, 32, 0, 1'b0);
    issue("u3_5", 1'b0, 32'd3, 32'd5, 64'h00000003_00000000, 32, 0, 1'b0);

    // T4: annul at cycle 10 of ON, with start still high
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    chk("annul_ready", 64'(ready), 64'd0);
    chk("annul_result", result, 64'd0);
    no_ready("annul_no_ready", 40);
    issue("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32, 0, 1'b0);

    // T5
    issue("s_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 32, 0, 1'b1);
    issue("u100_7_scr", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32, 0, 1'b1);

    // T6: reset at cycle 20 of ON
    signed_div = 1'b0; op1 = 32'd50; op2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_result", result, 64'd0);
    no_ready("midrst_no_ready", 40);
    issue("u1000_10_hold", 1'b0, 32'd1000, 32'd10, 64'h00000000_00000064, 32, 5, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
